pipeline_chain: RTL and testbench
=================================

# pipeline_chain

Parametrised multi-stage pipeline register chain with per-stage valid bits, stall, flush and bubble collapsing. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches into one block of configurable payload width and depth. It moves payloads forward under a valid/ready handshake and fills empty stages even while downstream stages are held. It sits between datapath stage logic and is the standard stage-latch for the next-generation pipelined datapath.

## Interface
Parameters:
- WIDTH, 32, payload bits per stage
- STAGES, 4, number of register stages (legal range 1–16)
- CNTW, 16, width of the killed-entry counter

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  upstream offers a payload
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  chain accepts the payload this cycle
- stall  in  STAGES  per-stage hold; bit i freezes stage i
- flush  in  STAGES  per-stage squash; bit i empties stage i
- out_valid  out  1  valid bit of stage STAGES-1
- out_data  out  WIDTH  payload register of stage STAGES-1
- out_ready  in  1  downstream consumes the output this cycle
- stage_valid  out  STAGES  valid bit of each stage
- occupancy  out  $clog2(STAGES+1)  count of valid stages, registered
- killed_count  out  CNTW  saturating count of valid entries destroyed by flush

## Operation
- Per stage i: valid[i] and data[i]. Stage 0 is the input end; stage STAGES-1 drives out_*.
- accept_STAGES = out_ready.
- advance_i = valid[i] & ~stall[i] & ~flush[i] & accept_(i+1).
- accept_i = ~flush[i] & ~stall[i] & (~valid[i] | advance_i).
- Bubble collapse: an empty, unstalled stage accepts from upstream even when a later stage is held.
- Load: when accept_i and the upstream entry is valid (valid[i-1], or in_valid for i=0), stage i takes the upstream data and sets valid. When accept_i and no upstream entry is valid, stage i clears valid and keeps its data.
- Stall: stage i holds valid and data. It neither accepts nor emits.
- Flush: valid[i] goes to 0 and data[i] goes to 0 (NOP encoding). Stage i refuses upstream that cycle, so upstream holds. Flush overrides stall.
- in_ready = accept_0. The ready path is combinational from out_ready through all stages.
- occupancy is the registered popcount of the next-state valid bits.
- killed_count adds popcount(flush & valid) each cycle and saturates at all-ones. With skid enabled it also counts a valid skid entry cleared by flush[0].

## Timing
- Reset values: all valid 0, all data 0, out_valid 0, out_data 0, stage_valid 0, occupancy 0, killed_count 0.
- in_ready after reset is ~stall[0] & ~flush[0]; with the skid buffer it is 1.
- Latency: an entry accepted in cycle N is presented on out_valid/out_data in cycle N+STAGES, with no stalls and out_ready held high.
- Throughput: one entry per cycle when unstalled.
- Full chain, out_ready low: in_ready 0, contents hold.
- Full chain, out_ready high: the chain shifts and accepts in the same cycle.
- Empty chain with in_valid low: no state change. killed_count does not change when flushing empty stages.
- Simultaneous flush[i] and a load into stage i+1 from stage i: stage i does not advance, and stage i+1 receives no entry (it clears valid).
- Simultaneous events are resolved in this order: flush, then stall, then load.
- Reset asserted mid-operation clears all state immediately, independent of CLK. The first edge after release behaves as from an empty chain.

## Configuration
- PIPELINE_CHAIN_SKID_EN defined:
  - Adds a one-entry skid register ahead of stage 0. in_ready becomes registered: in_ready = ~skid_valid.
  - An input offered while accept_0 is low is captured into the skid register.
  - While the skid register is full, it feeds stage 0 ahead of in_data.
  - flush[0] also clears the skid register.
  - Latency is unchanged when the skid register is empty, and one cycle longer for an entry that passes through it.
- PIPELINE_CHAIN_SKID_EN undefined: no skid register; in_ready is combinational as described in Operation.

## Test plan
- STAGES=4, WIDTH=32: inputs 0x1,0x2,0x3 on consecutive cycles with out_ready=1 -> 0x1,0x2,0x3 appear on out_data on cycles 4,5,6. occupancy peaks at 3.
- Fill the chain, then hold out_ready=0 for 3 cycles -> in_ready=0, contents unchanged, occupancy=4. Raise out_ready -> one entry leaves per cycle, in order.
- Chain holds entries only in stages 0 and 3, stall[3]=1 -> stage 0 moves into stage 1 (bubble collapse). in_ready=1 on the following cycle.
- Full chain, flush=4'b0110 for one cycle -> stage_valid=4'b1001, data[1]=data[2]=0, killed_count increments by 2. Stage 0 holds its entry.
- Apply stall[2] and flush[2] together on a valid stage -> stage 2 is emptied. Assert nRST low mid-stream -> all outputs return to their reset values immediately.
- With PIPELINE_CHAIN_SKID_EN, out_ready=0 and in_valid=1 -> the skid register captures one entry and in_ready drops on the next cycle. flush[0] -> skid cleared, in_ready=1, killed_count increments by 1.

Source files
------------

// File: rtl/pipeline_chain.sv
// pipeline_chain: parametrised stage-latch chain with per-stage valid bits,
// stall, flush and bubble collapsing under a valid/ready handshake.
// Optional build macro PIPELINE_CHAIN_SKID_EN adds a one-entry skid register
// ahead of stage 0, which makes in_ready a registered signal.
// When the skid register is full it feeds stage 0 ahead of in_data. A flush[0]
// empties it, and an input offered in that same cycle is discarded.
module pipeline_chain #(
   parameter int  WIDTH  = 32,
   parameter int  STAGES = 4,
   parameter int  CNTW   = 16,
   localparam int OCCW   = $clog2(STAGES + 1)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   output logic              in_ready,
   input  logic [STAGES-1:0] stall,
   input  logic [STAGES-1:0] flush,
   output logic              out_valid,
   output logic [WIDTH-1:0]  out_data,
   input  logic              out_ready,
   output logic [STAGES-1:0] stage_valid,
   output logic [OCCW-1:0]   occupancy,
   output logic [CNTW-1:0]   killed_count
);

   // Wide enough for every stage plus the skid entry dying in one cycle.
   localparam int KW = $clog2(STAGES + 2);

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [WIDTH-1:0]  data_q  [STAGES];
   logic [WIDTH-1:0]  data_d  [STAGES];
   logic [WIDTH-1:0]  up_data [STAGES];
   logic [STAGES:0]   accept;
   logic [STAGES-1:0] advance;
   logic [STAGES-1:0] load;
   logic              src_valid;
   logic [WIDTH-1:0]  src_data;
   logic              skid_kill;
   logic [KW-1:0]     kill_n;
   logic [OCCW-1:0]   occ_d;
   logic [CNTW:0]     kill_sum;

   // Ready chain: walks from the output end back to stage 0, so the ready path
   // is combinational from out_ready through every stage. Flush and stall both
   // block acceptance; an empty unstalled stage accepts even behind a held stage.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      accept         = '0;
      advance        = '0;
      load           = '0;
      accept[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         advance[i] = valid_q[i] & ~stall[i] & ~flush[i] & accept[i+1];
         accept[i]  = ~flush[i] & ~stall[i] & (~valid_q[i] | advance[i]);
      end
      // A stage only receives an entry its upstream neighbour actually releases,
      // so a flushed or stalled upstream stage delivers nothing.
      load[0] = accept[0] & src_valid;
      for (int i = 1; i < STAGES; i++) begin
         load[i] = advance[i-1];
      end
   end

`ifdef PIPELINE_CHAIN_SKID_EN
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;

   assign src_valid = skid_valid | in_valid;
   assign src_data  = skid_valid ? skid_data : in_data;
   assign in_ready  = ~skid_valid;
   assign skid_kill = skid_valid & flush[0];

   // Skid register: catches an offer stage 0 cannot take and drains into stage 0 first.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (flush[0]) begin
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (skid_valid) begin
         if (accept[0]) begin
            skid_valid <= 1'b0;
         end
      end else if (in_valid && !accept[0]) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end
`else
   assign src_valid = in_valid;
   assign src_data  = in_data;
   assign in_ready  = accept[0];
   assign skid_kill = 1'b0;
`endif

   // Next-state per stage, priority flush > stall > load.
   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      up_data[0] = src_data;
      for (int i = 1; i < STAGES; i++) begin
         up_data[i] = data_q[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
         if (flush[i]) begin
            valid_d[i] = 1'b0;
            data_d[i]  = '0;
         end else if (accept[i]) begin
            // Stall leaves accept low, so a stalled stage falls through and holds.
            valid_d[i] = load[i];
            if (load[i]) begin
               data_d[i] = up_data[i];
            end
         end
      end
   end

   // Occupancy and killed-entry tallies for this cycle.
   always_comb begin
      kill_n = KW'(skid_kill);
      occ_d  = '0;
      for (int i = 0; i < STAGES; i++) begin
         kill_n = kill_n + KW'(flush[i] & valid_q[i]);
         occ_d  = occ_d + OCCW'(valid_d[i]);
      end
      kill_sum = {1'b0, killed_count} + (CNTW + 1)'(kill_n);
   end

   // Stage registers and status counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= '0;
         // NOTE: payloads are reset too; a cleared stage must read as the all-zero NOP.
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
         occupancy    <= '0;
         killed_count <= '0;
      end else begin
         // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
         valid_q      <= valid_d;
         data_q       <= data_d;
         occupancy    <= occ_d;
         killed_count <= kill_sum[CNTW] ? '1 : kill_sum[CNTW-1:0];
      end
   end

   assign out_valid   = valid_q[STAGES-1];
   assign out_data    = data_q[STAGES-1];
   assign stage_valid = valid_q;

endmodule

// File: tb/tb_pipeline_chain.sv
// tb_pipeline_chain: directed stimulus with a scoreboard queue. Accepted
// inputs are pushed as they handshake; a monitor pops and compares every
// output handshake. Entries destroyed by flush or reset are removed by hand.
module tb_pipeline_chain;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;
   localparam int CNTW   = 16;
   localparam int OCCW   = $clog2(STAGES + 1);

   logic              CLK       = 1'b0;
   logic              nRST      = 1'b1;
   logic              in_valid  = 1'b0;
   logic [WIDTH-1:0]  in_data   = '0;
   logic              in_ready;
   logic [STAGES-1:0] stall     = '0;
   logic [STAGES-1:0] flush     = '0;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic              out_ready = 1'b0;
   logic [STAGES-1:0] stage_valid;
   logic [OCCW-1:0]   occupancy;
   logic [CNTW-1:0]   killed_count;

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] exp_q [$];

   pipeline_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNTW(CNTW)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .stall        (stall),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .stage_valid  (stage_valid),
      .occupancy    (occupancy),
      .killed_count (killed_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Remove an entry the bench destroyed on purpose; it must still be pending.
   task automatic drop_expected(input logic [WIDTH-1:0] v);
      int idx;
      idx = -1;
      foreach (exp_q[k]) if (idx < 0 && exp_q[k] == v) idx = k;
      total++;
      if (idx < 0) begin
         bad++;
         $display("FAIL drop: entry 0x%0h was never accepted", v);
      end else begin
         exp_q.delete(idx);
      end
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Four back-to-back entries into an empty chain with out_ready low.
   task automatic fill(input logic [WIDTH-1:0] base);
      out_ready = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         in_valid = 1'b1;
         in_data  = base + WIDTH'(k);
         tick();
      end
      in_valid = 1'b0;
   endtask

   // Scoreboard: both handshakes are sampled on the falling edge, half a cycle
   // before the rising edge that completes them.
   always @(negedge CLK) begin
      if (nRST && in_valid && in_ready) exp_q.push_back(in_data);
      if (nRST && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_unexpected: got 0x%0h with nothing pending", out_data);
         end else begin
            check("out_order", 64'(out_data), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 nRST = 1'b0;
      #10;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_stage_valid", 64'(stage_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_killed", 64'(killed_count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      nRST = 1'b1;

`ifdef PIPELINE_CHAIN_SKID_EN
      // Stage 0 stalled: the offer lands in the skid register.
      stall     = 4'b0001;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h5000;
      #1;
      check("skid_ready_before", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("skid_ready_full", 64'(in_ready), 64'd0);
      check("skid_stage_valid", 64'(stage_valid), 64'd0);
      // flush[0] clears the skid entry and counts it.
      flush = 4'b0001;
      tick();
      flush = '0;
      check("skid_flush_ready", 64'(in_ready), 64'd1);
      check("skid_flush_killed", 64'(killed_count), 64'd1);
      drop_expected(32'h5000);
      // Capture again, then release the stall so the skid entry feeds stage 0.
      in_valid = 1'b1;
      in_data  = 32'h5001;
      tick();
      in_valid = 1'b0;
      check("skid_ready_full2", 64'(in_ready), 64'd0);
      stall     = '0;
      out_ready = 1'b1;
      tick();
      check("skid_to_stage0", 64'(stage_valid), 64'b0001);
      check("skid_ready_free", 64'(in_ready), 64'd1);
      drain(10);
`else
      // 1,2,3 back to back: visible in cycles 4,5,6, occupancy peaks at 3.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h1;
      tick();
      in_data = 32'h2;
      tick();
      in_data = 32'h3;
      tick();
      in_valid = 1'b0;
      check("lat_occ_c3", 64'(occupancy), 64'd3);
      tick();
      check("lat_valid_c4", 64'(out_valid), 64'd1);
      check("lat_data_c4", 64'(out_data), 64'h1);
      check("lat_occ_c4", 64'(occupancy), 64'd3);
      tick();
      check("lat_data_c5", 64'(out_data), 64'h2);
      tick();
      check("lat_data_c6", 64'(out_data), 64'h3);
      tick();
      check("lat_empty_c7", 64'(out_valid), 64'd0);
      check("lat_occ_c7", 64'(occupancy), 64'd0);

      // Full chain held by out_ready low, then released while a new offer waits.
      fill(32'hA0);
      in_valid = 1'b1;
      in_data  = 32'hA4;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_stage_valid", 64'(stage_valid), 64'hF);
         check("hold_occupancy", 64'(occupancy), 64'd4);
         check("hold_out_data", 64'(out_data), 64'hA0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("full_shift_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      drain(10);

      // Bubble collapse: entries in stages 0 and 3, stage 3 stalled.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hB0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      in_valid = 1'b1;
      in_data  = 32'hB1;
      tick();
      in_valid = 1'b0;
      stall    = 4'b1000;
      check("bubble_before", 64'(stage_valid), 64'b1001);
      tick();
      check("bubble_after", 64'(stage_valid), 64'b1010);
      check("bubble_in_ready", 64'(in_ready), 64'd1);
      check("bubble_out_data", 64'(out_data), 64'hB0);
      stall     = '0;
      out_ready = 1'b1;
      drain(10);

      // Flush middle stages of a full chain; stage 0 holds its entry.
      fill(32'hC0);
      flush = 4'b0110;
      tick();
      flush = '0;
      check("flush_stage_valid", 64'(stage_valid), 64'b1001);
      check("flush_killed", 64'(killed_count), 64'd2);
      check("flush_occupancy", 64'(occupancy), 64'd2);
      check("flush_data1_nop", 64'(dut.data_q[1]), 64'd0);
      check("flush_data2_nop", 64'(dut.data_q[2]), 64'd0);
      drop_expected(32'hC1);
      drop_expected(32'hC2);
      out_ready = 1'b1;
      drain(10);

      // Stalled stage 0 on an empty chain refuses input.
      stall = 4'b0001;
      #1;
      check("stall0_in_ready", 64'(in_ready), 64'd0);
      stall = '0;

      // Flush beats stall on the same stage.
      fill(32'hD0);
      stall = 4'b0100;
      flush = 4'b0100;
      tick();
      stall = '0;
      flush = '0;
      check("stall_flush_valid", 64'(stage_valid), 64'b1011);
      check("stall_flush_killed", 64'(killed_count), 64'd3);
      drop_expected(32'hD1);

      // Reset mid-stream, away from any clock edge.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hE0;
      tick();
      in_valid = 1'b0;
      #2 nRST = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_data", 64'(out_data), 64'd0);
      check("mid_rst_stage_valid", 64'(stage_valid), 64'd0);
      check("mid_rst_occupancy", 64'(occupancy), 64'd0);
      check("mid_rst_killed", 64'(killed_count), 64'd0);
      exp_q.delete();
      tick();
      nRST = 1'b1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data  = 32'hF0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("post_rst_lat_valid", 64'(out_valid), 64'd1);
      check("post_rst_lat_data", 64'(out_data), 64'hF0);
      drain(5);
      check("post_rst_killed", 64'(killed_count), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
